gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 121 ++++++++++++
 tb/tb_gshare_predictor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor: a table of saturating counters indexed by
// PC (optionally XORed with global history), swept to weakly-not-taken after reset.
module gshare_predictor #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 2,
  parameter int GHR_W = 8,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic             pred_isbr,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  input  logic [GHR_W-1:0] upd_ghr,
  output logic             ready,
  output logic [31:0]      mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int INIT_VAL = (1 << (CNT_W - 1)) - 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_VAL);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_ptr;
  logic [GHR_W-1:0] ghr;
  logic [CNT_W-1:0] cnt_table [DEPTH];

  logic [IDX_W-1:0] pc_bits;
  logic [IDX_W-1:0] ghr_ext;
  logic [GHR_W:0]   spec_shift;
  logic [GHR_W:0]   rec_shift;
  logic [CNT_W-1:0] upd_cnt;
  logic [CNT_W-1:0] upd_cnt_next;
  logic             unused_pc;

  assign pc_bits   = pred_pc[IDX_W+1:2];
  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr;
  end

  assign pred_idx = (MODE == 0) ? pc_bits : (pc_bits ^ ghr_ext);
  assign pred_ghr = ghr;

  always_comb begin
    pred_taken = 1'b1;
    if (pred_isbr) pred_taken = ready ? cnt_table[pred_idx][CNT_W-1] : 1'b0;
  end

  // One extra bit keeps the shift expression legal when GHR_W is 1.
  assign spec_shift = {ghr, pred_taken};
  assign rec_shift  = {upd_ghr, upd_taken};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      INIT: if (init_ptr == '1) state_d = RUN;
      RUN:  ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 init_ptr <= '0;
    else if (state_q == INIT) init_ptr <= init_ptr + 1'b1;
  end

  always_comb begin
    upd_cnt      = cnt_table[upd_idx];
    upd_cnt_next = upd_cnt;
    if (upd_taken) begin
      if (upd_cnt != CNT_MAX) upd_cnt_next = upd_cnt + 1'b1;
    end else begin
      if (upd_cnt != '0) upd_cnt_next = upd_cnt - 1'b1;
    end
  end

  // NOTE: the counter table has no reset; the INIT sweep is what makes its contents defined.
  always_ff @(posedge clk) begin
    if (state_q == INIT)                 cnt_table[init_ptr] <= CNT_INIT;
    else if (upd_valid && ready && !rst) cnt_table[upd_idx]  <= upd_cnt_next;
  end

  // Mispredict recovery overrides a speculative shift in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (ready) begin
      if (upd_valid && upd_mispred)   ghr <= rec_shift[GHR_W-1:0];
      else if (pred_valid && pred_isbr) ghr <= spec_shift[GHR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      mispred_cnt <= '0;
    else if (ready && upd_valid && upd_mispred && (mispred_cnt != 32'hFFFF_FFFF))
      mispred_cnt <= mispred_cnt + 32'd1;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: a gshare, a bimodal and a wide-counter instance
// share clock and reset; expectations are queued as stimulus is driven.
module tb_gshare_predictor;

  typedef struct {
    string       name;
    logic [31:0] val;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] obs_q[$];
  int          checks = 0;
  int          errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // gshare instance (defaults)
  logic        g_pred_valid, g_pred_isbr, g_pred_taken, g_upd_valid, g_upd_taken, g_upd_mispred, g_ready;
  logic [31:0] g_pred_pc, g_mispred_cnt;
  logic [7:0]  g_pred_idx, g_pred_ghr, g_upd_idx, g_upd_ghr;

  // bimodal instance
  logic        b_pred_valid, b_pred_isbr, b_pred_taken, b_upd_valid, b_upd_taken, b_upd_mispred, b_ready;
  logic [31:0] b_pred_pc, b_mispred_cnt;
  logic [7:0]  b_pred_idx, b_pred_ghr, b_upd_idx, b_upd_ghr;

  // 3-bit counters, 4-bit history
  logic        w_pred_valid, w_pred_isbr, w_pred_taken, w_upd_valid, w_upd_taken, w_upd_mispred, w_ready;
  logic [31:0] w_pred_pc, w_mispred_cnt;
  logic [7:0]  w_pred_idx, w_upd_idx;
  logic [3:0]  w_pred_ghr, w_upd_ghr;

  gshare_predictor #(.IDX_W(8), .CNT_W(2), .GHR_W(8), .MODE(1)) u_gs (
    .clk(clk), .rst(rst), .pred_valid(g_pred_valid), .pred_pc(g_pred_pc), .pred_isbr(g_pred_isbr),
    .pred_taken(g_pred_taken), .pred_idx(g_pred_idx), .pred_ghr(g_pred_ghr), .upd_valid(g_upd_valid),
    .upd_idx(g_upd_idx), .upd_taken(g_upd_taken), .upd_mispred(g_upd_mispred), .upd_ghr(g_upd_ghr),
    .ready(g_ready), .mispred_cnt(g_mispred_cnt)
  );

  gshare_predictor #(.IDX_W(8), .CNT_W(2), .GHR_W(8), .MODE(0)) u_bm (
    .clk(clk), .rst(rst), .pred_valid(b_pred_valid), .pred_pc(b_pred_pc), .pred_isbr(b_pred_isbr),
    .pred_taken(b_pred_taken), .pred_idx(b_pred_idx), .pred_ghr(b_pred_ghr), .upd_valid(b_upd_valid),
    .upd_idx(b_upd_idx), .upd_taken(b_upd_taken), .upd_mispred(b_upd_mispred), .upd_ghr(b_upd_ghr),
    .ready(b_ready), .mispred_cnt(b_mispred_cnt)
  );

  gshare_predictor #(.IDX_W(8), .CNT_W(3), .GHR_W(4), .MODE(1)) u_w (
    .clk(clk), .rst(rst), .pred_valid(w_pred_valid), .pred_pc(w_pred_pc), .pred_isbr(w_pred_isbr),
    .pred_taken(w_pred_taken), .pred_idx(w_pred_idx), .pred_ghr(w_pred_ghr), .upd_valid(w_upd_valid),
    .upd_idx(w_upd_idx), .upd_taken(w_upd_taken), .upd_mispred(w_upd_mispred), .upd_ghr(w_upd_ghr),
    .ready(w_ready), .mispred_cnt(w_mispred_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {g_pred_valid, g_pred_isbr, g_upd_valid, g_upd_taken, g_upd_mispred} = '0;
    {b_pred_valid, b_pred_isbr, b_upd_valid, b_upd_taken, b_upd_mispred} = '0;
    {w_pred_valid, w_pred_isbr, w_upd_valid, w_upd_taken, w_upd_mispred} = '0;
    g_pred_pc = '0; b_pred_pc = '0; w_pred_pc = '0;
    g_upd_idx = '0; b_upd_idx = '0; w_upd_idx = '0;
    g_upd_ghr = '0; b_upd_ghr = '0; w_upd_ghr = '0;
  endtask

  task automatic expect_val(input string name, input logic [31:0] val);
    exp_q.push_back('{name, val});
  endtask

  task automatic test_reset();
    int n;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    expect_val("rst_ready", 0);        obs_q.push_back(32'(g_ready));
    expect_val("rst_ghr", 0);          obs_q.push_back(32'(g_pred_ghr));
    expect_val("rst_mispred_cnt", 0);  obs_q.push_back(g_mispred_cnt);
    rst = 1'b0;
    n = 0;
    while (g_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    expect_val("ready_latency", 256);  obs_q.push_back(32'(n));
    expect_val("bm_ready", 1);         obs_q.push_back(32'(b_ready));
    expect_val("w_ready", 1);          obs_q.push_back(32'(w_ready));
    expect_val("post_init_mispred_cnt", 0); obs_q.push_back(g_mispred_cnt);
    while (exp_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      logic [31:0] o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.val); end
    end
  endtask

  task automatic test_idle_lookup();
    g_pred_isbr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      g_pred_pc = 32'(i) << 2;
      #1;
      expect_val($sformatf("idle_taken[%0d]", i), 0);
      obs_q.push_back(32'(g_pred_taken));
    end
    g_pred_isbr = 1'b0;
    #1;
    expect_val("non_branch_taken", 1); obs_q.push_back(32'(g_pred_taken));
    while (exp_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      logic [31:0] o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.val); end
    end
  endtask

  task automatic test_bimodal();
    logic ups[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exps[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic lo_ups[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic lo_exps[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    b_pred_pc = 32'h40;
    b_pred_isbr = 1'b1;
    #1;
    expect_val("bm_initial_taken", 0); obs_q.push_back(32'(b_pred_taken));
    // Saturation at the top: four takens then two not-takens.
    for (int k = 0; k < 6; k++) begin
      b_upd_valid = 1'b1; b_upd_idx = 8'h10; b_upd_taken = ups[k];
      tick();
      b_upd_valid = 1'b0;
      #1;
      expect_val($sformatf("bm_hi_step%0d", k), 32'(exps[k])); obs_q.push_back(32'(b_pred_taken));
    end
    // Saturation at the bottom on entry 0x20.
    b_pred_pc = 32'h80;
    for (int k = 0; k < 4; k++) begin
      b_upd_valid = 1'b1; b_upd_idx = 8'h20; b_upd_taken = lo_ups[k];
      tick();
      b_upd_valid = 1'b0;
      #1;
      expect_val($sformatf("bm_lo_step%0d", k), 32'(lo_exps[k])); obs_q.push_back(32'(b_pred_taken));
    end
    b_pred_valid = 1'b1;
    tick();
    b_pred_valid = 1'b0;
    #1;
    expect_val("bm_ghr_after_shift", 1); obs_q.push_back(32'(b_pred_ghr));
    expect_val("bm_idx_ignores_ghr", 32'h20); obs_q.push_back(32'(b_pred_idx));
    b_pred_isbr = 1'b0;
    while (exp_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      logic [31:0] o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.val); end
    end
  endtask

  task automatic test_wide_counter();
    w_upd_valid = 1'b1; w_upd_mispred = 1'b1; w_upd_ghr = 4'h2; w_upd_taken = 1'b1; w_upd_idx = 8'h00;
    tick();
    w_upd_valid = 1'b0; w_upd_mispred = 1'b0;
    w_pred_pc = 32'h40; w_pred_isbr = 1'b1;
    #1;
    expect_val("w_ghr", 32'h5);          obs_q.push_back(32'(w_pred_ghr));
    expect_val("w_idx", 32'h15);         obs_q.push_back(32'(w_pred_idx));
    expect_val("w_taken", 0);            obs_q.push_back(32'(w_pred_taken));
    expect_val("w_mispred_cnt", 1);      obs_q.push_back(w_mispred_cnt);
    w_pred_isbr = 1'b0;
    while (exp_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      logic [31:0] o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.val); end
    end
  endtask

  task automatic test_ghr_recovery();
    logic [7:0] idxs[3] = '{8'h10, 8'h11, 8'h13};
    logic [7:0] ghrs[3] = '{8'h00, 8'h01, 8'h03};
    // Train the three entries the speculative path will visit to weakly taken.
    for (int k = 0; k < 3; k++) begin
      g_upd_valid = 1'b1; g_upd_idx = idxs[k]; g_upd_taken = 1'b1;
      tick();
    end
    g_upd_valid = 1'b0;
    g_pred_pc = 32'h40; g_pred_isbr = 1'b1; g_pred_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      expect_val($sformatf("spec_idx%0d", k), 32'(idxs[k])); obs_q.push_back(32'(g_pred_idx));
      expect_val($sformatf("spec_ghr%0d", k), 32'(ghrs[k])); obs_q.push_back(32'(g_pred_ghr));
      expect_val($sformatf("spec_taken%0d", k), 1);          obs_q.push_back(32'(g_pred_taken));
      tick();
    end
    g_pred_valid = 1'b0;
    #1;
    expect_val("ghr_after_3_taken", 32'h07); obs_q.push_back(32'(g_pred_ghr));
    // Recovery with a competing speculative lookup in the same cycle.
    g_pred_valid = 1'b1;
    g_upd_valid = 1'b1; g_upd_mispred = 1'b1; g_upd_ghr = 8'h01; g_upd_taken = 1'b0; g_upd_idx = 8'h50;
    tick();
    {g_pred_valid, g_upd_valid, g_upd_mispred} = '0;
    #1;
    expect_val("ghr_recovered", 32'h02);  obs_q.push_back(32'(g_pred_ghr));
    expect_val("mispred_cnt_one", 1);     obs_q.push_back(g_mispred_cnt);
    while (exp_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      logic [31:0] o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.val); end
    end
  endtask

  task automatic test_same_cycle();
    g_pred_pc = 32'h60; g_pred_isbr = 1'b1;
    g_upd_valid = 1'b1; g_upd_idx = 8'h1A; g_upd_taken = 1'b1; g_upd_mispred = 1'b0;
    #1;
    expect_val("same_idx", 32'h1A);      obs_q.push_back(32'(g_pred_idx));
    expect_val("same_cycle_taken", 0);   obs_q.push_back(32'(g_pred_taken));
    tick();
    g_upd_valid = 1'b0;
    #1;
    expect_val("next_cycle_taken", 1);   obs_q.push_back(32'(g_pred_taken));
    g_pred_isbr = 1'b0;
    while (exp_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      logic [31:0] o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.val); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Entry 0x10 still holds a trained value until the sweep reaches it.
    g_pred_pc = 32'h40; g_pred_isbr = 1'b1; g_pred_valid = 1'b1;
    #1;
    expect_val("sweep_taken_gated", 0); obs_q.push_back(32'(g_pred_taken));
    for (int k = 0; k < 100; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_val("ready_after_pulse", 0); obs_q.push_back(32'(g_ready));
    n = 0;
    while (g_ready !== 1'b1 && n < 300) begin
      if (n == 100) begin
        g_upd_valid = 1'b1; g_upd_idx = 8'h30; g_upd_taken = 1'b1; g_upd_mispred = 1'b1; g_upd_ghr = 8'hFF;
      end else begin
        {g_upd_valid, g_upd_mispred} = '0;
      end
      tick();
      n++;
    end
    {g_upd_valid, g_upd_mispred, g_pred_valid} = '0;
    #1;
    expect_val("resweep_latency", 256);   obs_q.push_back(32'(n));
    expect_val("resweep_ghr", 0);         obs_q.push_back(32'(g_pred_ghr));
    expect_val("resweep_mispred_cnt", 0); obs_q.push_back(g_mispred_cnt);
    expect_val("resweep_0x10_taken", 0);  obs_q.push_back(32'(g_pred_taken));
    g_pred_pc = 32'hC0;
    #1;
    expect_val("sweep_upd_0x30_taken", 0); obs_q.push_back(32'(g_pred_taken));
    g_upd_valid = 1'b1; g_upd_idx = 8'h30; g_upd_taken = 1'b1;
    tick();
    g_upd_valid = 1'b0;
    #1;
    expect_val("0x30_is_one_plus_one", 1); obs_q.push_back(32'(g_pred_taken));
    g_pred_isbr = 1'b0;
    while (exp_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      logic [31:0] o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_lookup();
    test_bimodal();
    test_wide_counter();
    test_ghr_recovery();
    test_same_cycle();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
